// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data-memory port: one request at a time, a programmable
// number of wait states, big-endian byte/halfword/word access, valid/ready response channel.
module dmem_responder #(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 2,
   parameter int unsigned CNT_W   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [0:31] req_addr,
   input  logic [0:31] req_wdata,
   input  logic        req_we,
   input  logic [0:1]  req_size,
   input  logic        req_sign,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [0:31] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] CntInit = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [0:31] addr_q, wdata_q;
   logic        we_q, sign_q;
   logic [0:1]  size_q;
   logic [0:31] rdata_q;
   logic        err_q;

   logic [0:31] mem [DEPTH];

   logic          accept, access;
   logic [0:31]   a_addr, a_wdata;
   logic          a_we, a_sign, a_err;
   logic [0:1]    a_size;
   logic [AW-1:0] idx;
   logic [1:0]    off;
   logic [0:31]   word, wr_word, rd_word;
   logic [7:0]    byte_v;
   logic [15:0]   half_v;
   logic          unused_addr;

   assign req_ready  = (state_q == StIdle) && reset;
   assign accept     = req_ready && req_valid;
   assign resp_valid = (state_q == StResp);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   // With zero wait states the access happens on the accepting edge, straight from the inputs.
   assign a_addr  = (state_q == StIdle) ? req_addr  : addr_q;
   assign a_wdata = (state_q == StIdle) ? req_wdata : wdata_q;
   assign a_we    = (state_q == StIdle) ? req_we    : we_q;
   assign a_size  = (state_q == StIdle) ? req_size  : size_q;
   assign a_sign  = (state_q == StIdle) ? req_sign  : sign_q;

   assign idx         = a_addr[30-AW:29];
   assign off         = a_addr[30:31];
   assign unused_addr = ^a_addr[0:29-AW];
   assign word        = mem[idx];
   assign byte_v      = word[8*off +: 8];
   assign half_v      = word[16*off[1] +: 16];

   assign a_err = (a_size == 2'b11) ||
                  (a_size == 2'b01 && a_addr[31]) ||
                  (a_size == 2'b10 && (a_addr[30] || a_addr[31]));

   always_comb begin
      access = 1'b0;
      if (LATENCY == 0) begin
         access = accept;
      end else begin
         access = (state_q == StWait) && (cnt_q == '0);
      end
   end

   always_comb begin
      rd_word = '0;
      wr_word = word;
      case (a_size)
         2'b00: begin
            rd_word = {{24{a_sign & byte_v[7]}}, byte_v};
            wr_word[8*off +: 8] = a_wdata[24:31];
         end
         2'b01: begin
            rd_word = {{16{a_sign & half_v[15]}}, half_v};
            wr_word[16*off[1] +: 16] = a_wdata[16:31];
         end
         2'b10: begin
            rd_word = word;
            wr_word = a_wdata;
         end
         default: ;
      endcase
      if (a_err || a_we) begin
         rd_word = '0;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               if (LATENCY == 0) begin
                  state_d = StResp;
               end else begin
                  state_d = StWait;
                  cnt_d   = CntInit;
               end
            end
         end
         StWait: begin
            if (cnt_q == '0) begin
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StResp: begin
            if (resp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         size_q  <= '0;
         sign_q  <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            we_q    <= req_we;
            size_q  <= req_size;
            sign_q  <= req_sign;
         end
         if (access) begin
            rdata_q <= rd_word;
            err_q   <= a_err;
         end
      end
   end

   // Storage survives reset; an access interrupted by reset never reaches this edge.
   always_ff @(posedge clk) begin
      if (access && a_we && !a_err) begin
         mem[idx] <= wr_word;
      end
   end

endmodule
